// File: rtl/dmem_arbiter.sv
// Two-port arbiter and sequencer for a single-ported data memory.
// Port 0 is the load/store unit and port 1 is a secondary master.
// The memory is granted round-robin. Strobes, address and write data are
// held stable for MEM_LAT cycles. A one-cycle response then goes back to
// the port that was granted. MEM_LAT must be in the range 1..15.
module dmem_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    // requester 0
    input  logic              req_valid_0,
    output logic              req_ready_0,
    input  logic              req_we_0,
    input  logic [ADDR_W-1:0] req_addr_0,
    input  logic [DATA_W-1:0] req_wdata_0,
    output logic              rsp_valid_0,
    output logic [DATA_W-1:0] rsp_rdata_0,
    // requester 1
    input  logic              req_valid_1,
    output logic              req_ready_1,
    input  logic              req_we_1,
    input  logic [ADDR_W-1:0] req_addr_1,
    input  logic [DATA_W-1:0] req_wdata_1,
    output logic              rsp_valid_1,
    output logic [DATA_W-1:0] rsp_rdata_1,
    // memory side
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // The counter holds the remaining ACCESS cycles minus one.
    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

    state_t            state_reg;
    state_t            state_next;
    logic              prio_reg;      // port that wins when both request
    logic [3:0]        cnt_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              gnt_reg;       // port owning the current access

    logic [1:0]        valid_vec;
    logic [1:0]        we_vec;
    logic [ADDR_W-1:0] addr_arr  [2];
    logic [DATA_W-1:0] wdata_arr [2];
    logic [DATA_W-1:0] rdata_arr [2];
    logic [1:0]        ready_vec;
    logic [1:0]        rsp_vec;

    logic              any_valid;
    logic              win_id;
    logic              accept;
    logic              capture;

    assign valid_vec    = {req_valid_1, req_valid_0};
    assign we_vec       = {req_we_1, req_we_0};
    assign addr_arr[0]  = req_addr_0;
    assign addr_arr[1]  = req_addr_1;
    assign wdata_arr[0] = req_wdata_0;
    assign wdata_arr[1] = req_wdata_1;

    // A single requester always wins; on a tie the priority pointer decides.
    assign any_valid = |valid_vec;
    assign win_id    = (&valid_vec) ? prio_reg : valid_vec[1];

    // The winner's ready is high whenever a request is present in IDLE,
    // so a handshake happens exactly when IDLE sees any valid.
    assign accept  = (state_reg == IDLE) && any_valid;
    assign capture = (state_reg == ACCESS) && (cnt_reg == 4'd0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: IDLE -> ACCESS on a handshake, then RESP after the
    // last strobe cycle, then back to IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (any_valid) state_next = ACCESS;
            ACCESS:  if (cnt_reg == 4'd0) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: request ready, memory strobes/bus, and response strobe.
    // The memory bus stays zero outside ACCESS. The strobes therefore only
    // ever appear together with the latched, stable address.
    always_comb begin
        ready_vec      = 2'b00;
        rsp_vec        = 2'b00;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        case (state_reg)
            IDLE: begin
                if (rst_n && any_valid) begin
                    ready_vec[win_id] = 1'b1;
                end
            end
            ACCESS: begin
                mem_read       = ~we_reg;
                mem_write      = we_reg;
                mem_address    = addr_reg;
                mem_write_data = wdata_reg;
            end
            RESP: begin
                rsp_vec[gnt_reg] = 1'b1;
            end
            default: begin
                ready_vec = 2'b00;
            end
        endcase
    end

    // Request latch, priority rotation and the ACCESS cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_reg  <= 1'b0;
            cnt_reg   <= 4'd0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            gnt_reg   <= 1'b0;
        end else if (accept) begin
            we_reg    <= we_vec[win_id];
            addr_reg  <= addr_arr[win_id];
            wdata_reg <= wdata_arr[win_id];
            gnt_reg   <= win_id;
            prio_reg  <= ~win_id;
            cnt_reg   <= LAT_LOAD;
        end else if ((state_reg == ACCESS) && (cnt_reg != 4'd0)) begin
            cnt_reg <= cnt_reg - 4'd1;
        end
    end

    // Per-port response data registers. Each one holds its value until the
    // next response to that port. Writes return zero.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [DATA_W-1:0] rdata_reg;

            // Capture read data (or zero for a write) on the last ACCESS cycle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_reg <= '0;
                end else if (capture && (gnt_reg == 1'(gi))) begin
                    rdata_reg <= we_reg ? '0 : mem_read_data;
                end
            end

            assign rdata_arr[gi] = rdata_reg;
        end
    endgenerate

    assign req_ready_0 = ready_vec[0];
    assign req_ready_1 = ready_vec[1];
    assign rsp_valid_0 = rsp_vec[0];
    assign rsp_valid_1 = rsp_vec[1];
    assign rsp_rdata_0 = rdata_arr[0];
    assign rsp_rdata_1 = rdata_arr[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter. Two instances are built, one with MEM_LAT=1 and
// one with MEM_LAT=4. Each has its own memory model, stimulus and reference
// model. The reference model predicts grants from the round-robin rule and
// uses cycle arithmetic for strobe/response timing. It also keeps its own
// copy of the memory contents for read data.
module tb_dmem_arbiter;

    logic clk;
    int   n_vec = 0;
    int   n_err = 0;
    logic done [2] = '{1'b0, 1'b0};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            localparam int LAT = (gi == 0) ? 1 : 4;

            logic        rst_n = 1'b1;
            logic        req_valid [2] = '{1'b0, 1'b0};
            logic        req_we    [2] = '{1'b0, 1'b0};
            logic [63:0] req_addr  [2] = '{64'd0, 64'd0};
            logic [63:0] req_wdata [2] = '{64'd0, 64'd0};
            logic        req_ready [2];
            logic        rsp_valid [2];
            logic [63:0] rsp_rdata [2];
            logic        mem_read, mem_write;
            logic [63:0] mem_address, mem_write_data, mem_read_data;
            logic [63:0] mem_dev   [1024];

            // reference model state
            logic [63:0] model_mem [1024];
            int          cyc       = 0;
            int          next_free = 0;
            int          last_win  = 1;
            int          acc_start = -10;
            int          acc_end   = -10;
            int          rsp_cyc   = -10;
            int          rsp_port  = 0;
            logic        exp_we    = 1'b0;
            logic [63:0] exp_addr  = 64'd0;
            logic [63:0] exp_wdata = 64'd0;
            logic [63:0] exp_rsp   = 64'd0;
            logic [63:0] exp_hold  [2] = '{64'd0, 64'd0};
            logic        acc_flag  [2] = '{1'b0, 1'b0};
            logic [63:0] amask     = 64'hFFFF_0000_0000_001F;

            dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(LAT)) u_dut (
                .clk            (clk),
                .rst_n          (rst_n),
                .req_valid_0    (req_valid[0]),
                .req_ready_0    (req_ready[0]),
                .req_we_0       (req_we[0]),
                .req_addr_0     (req_addr[0]),
                .req_wdata_0    (req_wdata[0]),
                .rsp_valid_0    (rsp_valid[0]),
                .rsp_rdata_0    (rsp_rdata[0]),
                .req_valid_1    (req_valid[1]),
                .req_ready_1    (req_ready[1]),
                .req_we_1       (req_we[1]),
                .req_addr_1     (req_addr[1]),
                .req_wdata_1    (req_wdata[1]),
                .rsp_valid_1    (rsp_valid[1]),
                .rsp_rdata_1    (rsp_rdata[1]),
                .mem_read       (mem_read),
                .mem_write      (mem_write),
                .mem_address    (mem_address),
                .mem_write_data (mem_write_data),
                .mem_read_data  (mem_read_data)
            );

            // memory device: combinational read, write while strobe is high
            assign mem_read_data = mem_dev[mem_address[9:0]];
            always @(posedge clk) begin
                if (mem_write) mem_dev[mem_address[9:0]] <= mem_write_data;
            end

            always @(posedge clk) cyc <= cyc + 1;

            // reference checker, sampled mid-cycle
            always @(negedge clk) begin
                if (!rst_n) begin
                    chk($sformatf("L%0d rst_ready0", LAT), 64'(req_ready[0]), 64'd0);
                    chk($sformatf("L%0d rst_ready1", LAT), 64'(req_ready[1]), 64'd0);
                    chk($sformatf("L%0d rst_mem_rd", LAT), 64'(mem_read), 64'd0);
                    chk($sformatf("L%0d rst_mem_wr", LAT), 64'(mem_write), 64'd0);
                    chk($sformatf("L%0d rst_mem_addr", LAT), mem_address, 64'd0);
                    chk($sformatf("L%0d rst_mem_wd", LAT), mem_write_data, 64'd0);
                    chk($sformatf("L%0d rst_rsp_v0", LAT), 64'(rsp_valid[0]), 64'd0);
                    chk($sformatf("L%0d rst_rsp_v1", LAT), 64'(rsp_valid[1]), 64'd0);
                    chk($sformatf("L%0d rst_rdata0", LAT), rsp_rdata[0], 64'd0);
                    chk($sformatf("L%0d rst_rdata1", LAT), rsp_rdata[1], 64'd0);
                    next_free = 0;
                    last_win  = 1;
                    acc_start = -10;
                    acc_end   = -10;
                    rsp_cyc   = -10;
                    exp_hold[0] = 64'd0;
                    exp_hold[1] = 64'd0;
                    acc_flag[0] = 1'b0;
                    acc_flag[1] = 1'b0;
                end else begin
                    logic exp_rdy [2];
                    logic act;
                    int   win;
                    win = (req_valid[0] && req_valid[1]) ? (1 - last_win) : (req_valid[0] ? 0 : 1);
                    for (int p = 0; p < 2; p++) begin
                        exp_rdy[p] = (cyc >= next_free) && (req_valid[0] || req_valid[1]) && (win == p);
                        chk($sformatf("L%0d ready%0d c%0d", LAT, p, cyc), 64'(req_ready[p]), 64'(exp_rdy[p]));
                    end
                    act = (cyc >= acc_start) && (cyc <= acc_end);
                    chk($sformatf("L%0d mem_rd c%0d", LAT, cyc), 64'(mem_read), 64'(act && !exp_we));
                    chk($sformatf("L%0d mem_wr c%0d", LAT, cyc), 64'(mem_write), 64'(act && exp_we));
                    chk($sformatf("L%0d mem_addr c%0d", LAT, cyc), mem_address, act ? exp_addr : 64'd0);
                    chk($sformatf("L%0d mem_wd c%0d", LAT, cyc), mem_write_data, act ? exp_wdata : 64'd0);
                    for (int p = 0; p < 2; p++) begin
                        logic rv;
                        rv = (cyc == rsp_cyc) && (rsp_port == p);
                        if (rv) exp_hold[p] = exp_rsp;
                        chk($sformatf("L%0d rsp_v%0d c%0d", LAT, p, cyc), 64'(rsp_valid[p]), 64'(rv));
                        chk($sformatf("L%0d rdata%0d c%0d", LAT, p, cyc), rsp_rdata[p], exp_hold[p]);
                        acc_flag[p] = exp_rdy[p];
                    end
                    if (exp_rdy[0] || exp_rdy[1]) begin
                        acc_start = cyc + 1;
                        acc_end   = cyc + LAT;
                        rsp_cyc   = cyc + LAT + 1;
                        next_free = cyc + LAT + 2;
                        last_win  = win;
                        rsp_port  = win;
                        exp_we    = req_we[win];
                        exp_addr  = req_addr[win];
                        exp_wdata = req_wdata[win];
                        exp_rsp   = exp_we ? 64'd0 : model_mem[exp_addr[9:0]];
                        if (exp_we) model_mem[exp_addr[9:0]] = exp_wdata;
                        $display("[L%0d] c%0d port%0d %s addr=%h data=%h", LAT, cyc, win,
                                 exp_we ? "WR" : "RD", exp_addr, exp_we ? exp_wdata : exp_rsp);
                    end
                end
            end

            // present one request and hold it until it is accepted
            task automatic do_req(input int p, input logic we, input logic [63:0] a, input logic [63:0] d);
                logic got;
                got = 1'b0;
                req_valid[p] = 1'b1;
                req_we[p]    = we;
                req_addr[p]  = a;
                req_wdata[p] = d;
                for (int k = 0; k < 100; k++) begin
                    @(posedge clk);
                    if (acc_flag[p]) begin
                        got = 1'b1;
                        break;
                    end
                end
                #1;
                req_valid[p] = 1'b0;
                chk($sformatf("L%0d accept_timeout p%0d", LAT, p), 64'(got), 64'd1);
            endtask

            initial begin
                for (int i = 0; i < 1024; i++) begin
                    mem_dev[i]   = 64'(i * 9 + 1);
                    model_mem[i] = 64'(i * 9 + 1);
                end
                #1 rst_n = 1'b0;
                repeat (3) @(posedge clk);
                #1 rst_n = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                chk($sformatf("L%0d idle_ready0", LAT), 64'(req_ready[0]), 64'd0);

                // write then read back on port 0
                do_req(0, 1'b1, 64'd5, 64'hDEAD_BEEF);
                repeat (LAT + 1) @(posedge clk);
                #1 chk($sformatf("L%0d wr_rsp0", LAT), rsp_rdata[0], 64'd0);
                do_req(0, 1'b0, 64'd5, 64'd0);
                repeat (LAT + 1) @(posedge clk);
                #1 chk($sformatf("L%0d rd_back5", LAT), rsp_rdata[0], 64'hDEAD_BEEF);

                // preloaded contents via port 1
                do_req(1, 1'b0, 64'd0, 64'd0);
                repeat (LAT + 1) @(posedge clk);
                #1 chk($sformatf("L%0d preload0", LAT), rsp_rdata[1], 64'd1);
                do_req(1, 1'b0, 64'd1, 64'd0);
                repeat (LAT + 1) @(posedge clk);
                #1 chk($sformatf("L%0d preload1", LAT), rsp_rdata[1], 64'd10);

                // reset during the access: strobe must drop at once
                do_req(0, 1'b0, 64'd7, 64'd0);
                repeat ((LAT > 1) ? 1 : 0) @(posedge clk);
                #1 chk($sformatf("L%0d mid_rd_pre", LAT), 64'(mem_read), 64'd1);
                rst_n = 1'b0;
                #1 chk($sformatf("L%0d mid_rd_drop", LAT), 64'(mem_read), 64'd0);
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
                do_req(1, 1'b0, 64'd1, 64'd0);
                repeat (LAT + 1) @(posedge clk);
                #1 chk($sformatf("L%0d post_rst", LAT), rsp_rdata[1], 64'd10);

                // contention: both ports keep reading addr 0 / addr 1
                for (int n = 0; n < 6 * (LAT + 2); n++) begin
                    for (int p = 0; p < 2; p++) begin
                        req_valid[p] = 1'b1;
                        req_we[p]    = 1'b0;
                        req_addr[p]  = 64'(p);
                    end
                    @(posedge clk);
                    #1;
                end
                req_valid[0] = 1'b0;
                req_valid[1] = 1'b0;
                repeat (LAT + 3) @(posedge clk);
                #1;

                // random traffic
                for (int n = 0; n < 400; n++) begin
                    for (int p = 0; p < 2; p++) begin
                        logic was_idle;
                        was_idle = !req_valid[p];
                        if (acc_flag[p]) req_valid[p] = 1'b0;
                        else if (req_valid[p] && ($urandom_range(0, 15) == 0)) req_valid[p] = 1'b0;
                        if (was_idle && ($urandom_range(0, 2) == 0)) begin
                            req_valid[p] = 1'b1;
                            req_we[p]    = 1'($urandom_range(0, 1));
                            req_addr[p]  = {$urandom, $urandom} & amask;
                            req_wdata[p] = {$urandom, $urandom};
                        end
                    end
                    @(posedge clk);
                    #1;
                end
                req_valid[0] = 1'b0;
                req_valid[1] = 1'b0;
                repeat (LAT + 3) @(posedge clk);
                done[gi] = 1'b1;
            end
        end
    endgenerate

    initial begin
        for (int i = 0; i < 20000; i++) begin
            if (done[0] && done[1]) break;
            @(posedge clk);
        end
        chk("run_timeout", 64'(done[0] && done[1]), 64'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
